// File: rtl/regfile_writeback_seq_if.sv
// ============================================================================
// regfile_writeback_seq_if : request, load-data and register-file write bus
//                            of the writeback sequencer.
// Rev 1.0
// Optional: REGFILE_WB_BASE_WRITEBACK_EN adds req_wb / req_rn / req_base.
// ============================================================================
`default_nettype none

interface regfile_writeback_seq_if #(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_multi;
  logic [ADDR_WIDTH-1:0] req_rd;
  logic [WORD_SIZE-1:0]  req_data;
  logic [NUM_REGS-1:0]   req_reglist;
  logic                  req_set_flags;
  logic [WORD_SIZE-1:0]  req_flags;
`ifdef REGFILE_WB_BASE_WRITEBACK_EN
  logic                  req_wb;
  logic [ADDR_WIDTH-1:0] req_rn;
  logic [WORD_SIZE-1:0]  req_base;
`endif
  logic                  mem_valid;
  logic                  mem_ready;
  logic [WORD_SIZE-1:0]  mem_data;
  logic                  rd_we;
  logic [WORD_SIZE-1:0]  rd_in;
  logic [ADDR_WIDTH-1:0] write_rd;
  logic                  pc_we;
  logic [WORD_SIZE-1:0]  pc_in;
  logic                  cpsr_we;
  logic [WORD_SIZE-1:0]  cpsr_in;
  logic                  busy;

  // Upstream side: issues requests and load beats, observes register writes.
  modport master (
    output req_valid, req_multi, req_rd, req_data, req_reglist, req_set_flags, req_flags,
`ifdef REGFILE_WB_BASE_WRITEBACK_EN
    output req_wb, req_rn, req_base,
`endif
    output mem_valid, mem_data,
    input  req_ready, mem_ready, rd_we, rd_in, write_rd, pc_we, pc_in, cpsr_we, cpsr_in, busy
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_multi, req_rd, req_data, req_reglist, req_set_flags, req_flags,
`ifdef REGFILE_WB_BASE_WRITEBACK_EN
    input  req_wb, req_rn, req_base,
`endif
    input  mem_valid, mem_data,
    output req_ready, mem_ready, rd_we, rd_in, write_rd, pc_we, pc_in, cpsr_we, cpsr_in, busy
  );
endinterface

`default_nettype wire

// File: rtl/regfile_writeback_seq.sv
// ============================================================================
// regfile_writeback_seq : serializes single and load-multiple writebacks into
//                         one register-file write per cycle, r15 -> PC port.
// Rev 1.0
// Optional: REGFILE_WB_BASE_WRITEBACK_EN enables base-register writeback.
// ============================================================================
`default_nettype none

module regfile_writeback_seq #(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               abort,
  regfile_writeback_seq_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] c_PC_IDX = ADDR_WIDTH'(15);

`ifdef REGFILE_WB_BASE_WRITEBACK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BURST = 2'd1, S_BASE_WB = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BURST = 2'd1} state_t;
`endif

  state_t                state_q, state_d;
  logic [NUM_REGS-1:0]   mask_q, mask_d;

  logic                  rd_we_q, rd_we_d;
  logic [WORD_SIZE-1:0]  rd_in_q, rd_in_d;
  logic [ADDR_WIDTH-1:0] write_rd_q, write_rd_d;
  logic                  pc_we_q, pc_we_d;
  logic [WORD_SIZE-1:0]  pc_in_q, pc_in_d;
  logic                  cpsr_we_q, cpsr_we_d;
  logic [WORD_SIZE-1:0]  cpsr_in_q, cpsr_in_d;

  logic                  w_req_fire;
  logic                  w_beat_fire;
  logic [ADDR_WIDTH-1:0] w_low_idx;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [WORD_SIZE-1:0]  w_wr_data;

  assign bus.req_ready = (state_q == S_IDLE) && !abort;
  assign bus.mem_ready = (state_q == S_BURST) && !abort;
  assign bus.busy      = (state_q != S_IDLE);

  assign w_req_fire  = bus.req_valid && bus.req_ready;
  assign w_beat_fire = bus.mem_valid && bus.mem_ready;

  assign bus.rd_we    = rd_we_q;
  assign bus.rd_in    = rd_in_q;
  assign bus.write_rd = write_rd_q;
  assign bus.pc_we    = pc_we_q;
  assign bus.pc_in    = pc_in_q;
  assign bus.cpsr_we  = cpsr_we_q;
  assign bus.cpsr_in  = cpsr_in_q;

  // Lowest pending register: beats arrive in ascending register order.
  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask_q[i]) w_low_idx = ADDR_WIDTH'(i);
    end
  end

`ifdef REGFILE_WB_BASE_WRITEBACK_EN
  logic                  wb_en_q;
  logic [ADDR_WIDTH-1:0] rn_q;
  logic [WORD_SIZE-1:0]  base_q;
  logic [ADDR_WIDTH:0]   w_pop;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_pop = w_pop + {{ADDR_WIDTH{1'b0}}, bus.req_reglist[i]};
    end
  end

  // Final base value is precomputed at accept so BASE_WB only replays it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_en_q <= 1'b0;
      rn_q    <= '0;
      base_q  <= '0;
    end else if (w_req_fire && bus.req_multi) begin
      wb_en_q <= bus.req_wb && !bus.req_reglist[bus.req_rn];
      rn_q    <= bus.req_rn;
      base_q  <= bus.req_base + (WORD_SIZE'(w_pop) << 2);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    w_wr_en    = 1'b0;
    w_wr_addr  = '0;
    w_wr_data  = '0;
    cpsr_we_d  = 1'b0;
    cpsr_in_d  = '0;
    rd_we_d    = 1'b0;
    rd_in_d    = '0;
    write_rd_d = '0;
    pc_we_d    = 1'b0;
    pc_in_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (w_req_fire) begin
          if (!bus.req_multi) begin
            w_wr_en   = 1'b1;
            w_wr_addr = bus.req_rd;
            w_wr_data = bus.req_data;
            if (bus.req_set_flags) begin
              cpsr_we_d = 1'b1;
              cpsr_in_d = bus.req_flags;
            end
          end else if (bus.req_reglist != '0) begin
            mask_d  = bus.req_reglist;
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (w_beat_fire) begin
          w_wr_en   = 1'b1;
          w_wr_addr = w_low_idx;
          w_wr_data = bus.mem_data;
          mask_d    = mask_q & (mask_q - NUM_REGS'(1));
          if (mask_d == '0) begin
`ifdef REGFILE_WB_BASE_WRITEBACK_EN
            state_d = wb_en_q ? S_BASE_WB : S_IDLE;
`else
            state_d = S_IDLE;
`endif
          end
        end
      end
`ifdef REGFILE_WB_BASE_WRITEBACK_EN
      S_BASE_WB: begin
        w_wr_en   = 1'b1;
        w_wr_addr = rn_q;
        w_wr_data = base_q;
        state_d   = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Abort only drops work not yet registered; a base write is cancelled too.
    if (abort) begin
      state_d   = S_IDLE;
      mask_d    = '0;
      w_wr_en   = 1'b0;
      cpsr_we_d = 1'b0;
      cpsr_in_d = '0;
    end

    if (w_wr_en) begin
      if (w_wr_addr == c_PC_IDX) begin
        pc_we_d = 1'b1;
        pc_in_d = w_wr_data;
      end else begin
        rd_we_d    = 1'b1;
        write_rd_d = w_wr_addr;
        rd_in_d    = w_wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      rd_we_q    <= 1'b0;
      rd_in_q    <= '0;
      write_rd_q <= '0;
      pc_we_q    <= 1'b0;
      pc_in_q    <= '0;
      cpsr_we_q  <= 1'b0;
      cpsr_in_q  <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      rd_we_q    <= rd_we_d;
      rd_in_q    <= rd_in_d;
      write_rd_q <= write_rd_d;
      pc_we_q    <= pc_we_d;
      pc_in_q    <= pc_in_d;
      cpsr_we_q  <= cpsr_we_d;
      cpsr_in_q  <= cpsr_in_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback_seq.sv
// ============================================================================
// tb_regfile_writeback_seq : directed self-checking bench for the sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_writeback_seq;

  logic clk;
  logic reset;
  logic abort;
  int   checks;
  int   errors;

  regfile_writeback_seq_if #(.WORD_SIZE(32), .NUM_REGS(16), .ADDR_WIDTH(4)) bus ();

  regfile_writeback_seq #(.WORD_SIZE(32), .NUM_REGS(16), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .abort (abort),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.req_valid = 0; bus.req_multi = 0; bus.req_rd = '0; bus.req_data = '0;
    bus.req_reglist = '0; bus.req_set_flags = 0; bus.req_flags = '0;
    bus.mem_valid = 0; bus.mem_data = '0; abort = 0;
`ifdef REGFILE_WB_BASE_WRITEBACK_EN
    bus.req_wb = 0; bus.req_rn = '0; bus.req_base = '0;
`endif
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (bus.rd_we !== 1'b0) begin errors++; $display("FAIL reset_rd_we got %b exp 0", bus.rd_we); end
    checks++; if (bus.pc_we !== 1'b0) begin errors++; $display("FAIL reset_pc_we got %b exp 0", bus.pc_we); end
    checks++; if (bus.cpsr_we !== 1'b0) begin errors++; $display("FAIL reset_cpsr_we got %b exp 0", bus.cpsr_we); end
    checks++; if (bus.rd_in !== 32'h0 || bus.write_rd !== 4'h0) begin errors++; $display("FAIL reset_data got %h/%h exp 0/0", bus.rd_in, bus.write_rd); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready got %b exp 0", bus.mem_ready); end
    reset = 0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
  endtask

  task automatic test_single();
    bus.req_valid = 1; bus.req_multi = 0; bus.req_rd = 4'd3; bus.req_data = 32'h12345678;
    @(negedge clk);
    bus.req_valid = 0;
    checks++; if (bus.rd_we !== 1'b1 || bus.write_rd !== 4'd3) begin errors++; $display("FAIL single_we got %b/%0d exp 1/3", bus.rd_we, bus.write_rd); end
    checks++; if (bus.rd_in !== 32'h12345678) begin errors++; $display("FAIL single_data got %h exp 12345678", bus.rd_in); end
    checks++; if (bus.pc_we !== 1'b0 || bus.cpsr_we !== 1'b0) begin errors++; $display("FAIL single_side got pc %b cpsr %b exp 0 0", bus.pc_we, bus.cpsr_we); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", bus.busy); end
    @(negedge clk);
    checks++; if ({bus.rd_we, bus.pc_we, bus.cpsr_we} !== 3'b000 || bus.rd_in !== 32'h0 || bus.write_rd !== 4'h0) begin
      errors++; $display("FAIL single_after got we %b%b%b rd_in %h exp all 0", bus.rd_we, bus.pc_we, bus.cpsr_we, bus.rd_in); end
  endtask

  task automatic test_pc_flags();
    bus.req_valid = 1; bus.req_multi = 0; bus.req_rd = 4'd15; bus.req_data = 32'h100;
    bus.req_set_flags = 1; bus.req_flags = 32'h60000000;
    @(negedge clk);
    bus.req_valid = 0; bus.req_set_flags = 0;
    checks++; if (bus.pc_we !== 1'b1 || bus.pc_in !== 32'h100) begin errors++; $display("FAIL pc_write got %b/%h exp 1/100", bus.pc_we, bus.pc_in); end
    checks++; if (bus.rd_we !== 1'b0 || bus.write_rd !== 4'd0) begin errors++; $display("FAIL pc_no_rd got %b/%0d exp 0/0", bus.rd_we, bus.write_rd); end
    checks++; if (bus.cpsr_we !== 1'b1 || bus.cpsr_in !== 32'h60000000) begin errors++; $display("FAIL cpsr_write got %b/%h exp 1/60000000", bus.cpsr_we, bus.cpsr_in); end
    // back-to-back singles, one per cycle
    bus.req_valid = 1; bus.req_rd = 4'd1; bus.req_data = 32'hAA;
    @(negedge clk);
    bus.req_rd = 4'd2; bus.req_data = 32'hBB;
    checks++; if (bus.rd_we !== 1'b1 || bus.write_rd !== 4'd1 || bus.rd_in !== 32'hAA || bus.cpsr_we !== 1'b0) begin
      errors++; $display("FAIL b2b_first got %b/%0d/%h exp 1/1/aa", bus.rd_we, bus.write_rd, bus.rd_in); end
    @(negedge clk);
    bus.req_valid = 0;
    checks++; if (bus.rd_we !== 1'b1 || bus.write_rd !== 4'd2 || bus.rd_in !== 32'hBB) begin
      errors++; $display("FAIL b2b_second got %b/%0d/%h exp 1/2/bb", bus.rd_we, bus.write_rd, bus.rd_in); end
    @(negedge clk);
  endtask

  task automatic test_burst();
    bus.req_valid = 1; bus.req_multi = 1; bus.req_reglist = 16'h8005; bus.req_set_flags = 1; bus.req_flags = 32'hF0000000;
    @(negedge clk);
    bus.req_valid = 0; bus.req_multi = 0; bus.req_set_flags = 0;
    checks++; if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0 || bus.mem_ready !== 1'b1) begin
      errors++; $display("FAIL burst_enter got busy %b rdy %b mrdy %b exp 1 0 1", bus.busy, bus.req_ready, bus.mem_ready); end
    checks++; if (bus.rd_we !== 1'b0 || bus.cpsr_we !== 1'b0) begin errors++; $display("FAIL burst_accept_nowrite got %b/%b exp 0/0", bus.rd_we, bus.cpsr_we); end
    bus.mem_valid = 1; bus.mem_data = 32'hA;
    @(negedge clk);
    bus.mem_valid = 0;
    checks++; if (bus.rd_we !== 1'b1 || bus.write_rd !== 4'd0 || bus.rd_in !== 32'hA) begin
      errors++; $display("FAIL burst_r0 got %b/%0d/%h exp 1/0/a", bus.rd_we, bus.write_rd, bus.rd_in); end
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      checks++; if (bus.rd_we !== 1'b0 || bus.pc_we !== 1'b0 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL burst_gap%0d got we %b pc %b busy %b exp 0 0 1", g, bus.rd_we, bus.pc_we, bus.busy); end
    end
    bus.mem_valid = 1; bus.mem_data = 32'hB;
    @(negedge clk);
    bus.mem_data = 32'hC;
    checks++; if (bus.rd_we !== 1'b1 || bus.write_rd !== 4'd2 || bus.rd_in !== 32'hB || bus.busy !== 1'b1) begin
      errors++; $display("FAIL burst_r2 got %b/%0d/%h busy %b exp 1/2/b 1", bus.rd_we, bus.write_rd, bus.rd_in, bus.busy); end
    @(negedge clk);
    bus.mem_valid = 0;
    checks++; if (bus.pc_we !== 1'b1 || bus.pc_in !== 32'hC || bus.rd_we !== 1'b0 || bus.write_rd !== 4'd0) begin
      errors++; $display("FAIL burst_pc got pc %b/%h rd %b/%0d exp 1/c 0/0", bus.pc_we, bus.pc_in, bus.rd_we, bus.write_rd); end
    checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL burst_done got rdy %b busy %b exp 1 0", bus.req_ready, bus.busy); end
    @(negedge clk);
    checks++; if (bus.pc_we !== 1'b0 || bus.cpsr_we !== 1'b0) begin errors++; $display("FAIL burst_tail got %b/%b exp 0/0", bus.pc_we, bus.cpsr_we); end
  endtask

  task automatic test_empty_list();
    bus.req_valid = 1; bus.req_multi = 1; bus.req_reglist = 16'h0000;
    bus.mem_valid = 1; bus.mem_data = 32'hDEAD;
    @(negedge clk);
    bus.req_valid = 0; bus.req_multi = 0;
    checks++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL empty_state got busy %b rdy %b exp 0 1", bus.busy, bus.req_ready); end
    @(negedge clk);
    bus.mem_valid = 0;
    checks++; if (bus.rd_we !== 1'b0 || bus.pc_we !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL empty_nowrite got rd %b pc %b busy %b exp 0 0 0", bus.rd_we, bus.pc_we, bus.busy); end
  endtask

  task automatic test_abort();
    bus.req_valid = 1; bus.req_multi = 1; bus.req_reglist = 16'h000F;
    @(negedge clk);
    bus.req_valid = 0; bus.req_multi = 0;
    bus.mem_valid = 1; bus.mem_data = 32'h11;
    @(negedge clk);
    bus.mem_data = 32'h22;
    checks++; if (bus.rd_we !== 1'b1 || bus.write_rd !== 4'd0 || bus.rd_in !== 32'h11) begin
      errors++; $display("FAIL abort_r0 got %b/%0d/%h exp 1/0/11", bus.rd_we, bus.write_rd, bus.rd_in); end
    @(negedge clk);
    bus.mem_data = 32'h33; abort = 1;
    checks++; if (bus.rd_we !== 1'b1 || bus.write_rd !== 4'd1 || bus.rd_in !== 32'h22) begin
      errors++; $display("FAIL abort_r1 got %b/%0d/%h exp 1/1/22", bus.rd_we, bus.write_rd, bus.rd_in); end
    #1;
    checks++; if (bus.mem_ready !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL abort_ready got mrdy %b rdy %b exp 0 0", bus.mem_ready, bus.req_ready); end
    @(negedge clk);
    abort = 0; bus.mem_valid = 0;
    checks++; if (bus.rd_we !== 1'b0 || bus.pc_we !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_cancel got rd %b pc %b busy %b exp 0 0 0", bus.rd_we, bus.pc_we, bus.busy); end
    bus.req_valid = 1; bus.req_rd = 4'd5; bus.req_data = 32'h55;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort_resume_ready got %b exp 1", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 0;
    checks++; if (bus.rd_we !== 1'b1 || bus.write_rd !== 4'd5 || bus.rd_in !== 32'h55) begin
      errors++; $display("FAIL abort_resume got %b/%0d/%h exp 1/5/55", bus.rd_we, bus.write_rd, bus.rd_in); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    bus.req_valid = 1; bus.req_multi = 1; bus.req_reglist = 16'h0030;
    @(negedge clk);
    bus.req_valid = 0; bus.req_multi = 0;
    bus.mem_valid = 1; bus.mem_data = 32'h77;
    @(negedge clk);
    reset = 1;
    #1;
    checks++; if (bus.rd_we !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid got rd %b busy %b exp 0 0", bus.rd_we, bus.busy); end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    bus.mem_valid = 0;
    checks++; if (bus.rd_we !== 1'b0 || bus.busy !== 1'b0 || bus.mem_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after got rd %b busy %b mrdy %b exp 0 0 0", bus.rd_we, bus.busy, bus.mem_ready); end
  endtask

`ifdef REGFILE_WB_BASE_WRITEBACK_EN
  task automatic test_base_wb();
    for (int pass = 0; pass < 2; pass++) begin
      bus.req_valid = 1; bus.req_multi = 1; bus.req_reglist = 16'h0006;
      bus.req_wb = 1; bus.req_rn = (pass == 0) ? 4'd13 : 4'd2; bus.req_base = 32'h1000;
      @(negedge clk);
      bus.req_valid = 0; bus.req_multi = 0; bus.req_wb = 0;
      bus.mem_valid = 1; bus.mem_data = 32'h21;
      @(negedge clk);
      bus.mem_data = 32'h22;
      checks++; if (bus.rd_we !== 1'b1 || bus.write_rd !== 4'd1 || bus.rd_in !== 32'h21) begin
        errors++; $display("FAIL basewb%0d_r1 got %b/%0d/%h exp 1/1/21", pass, bus.rd_we, bus.write_rd, bus.rd_in); end
      @(negedge clk);
      bus.mem_valid = 0;
      checks++; if (bus.rd_we !== 1'b1 || bus.write_rd !== 4'd2 || bus.rd_in !== 32'h22) begin
        errors++; $display("FAIL basewb%0d_r2 got %b/%0d/%h exp 1/2/22", pass, bus.rd_we, bus.write_rd, bus.rd_in); end
      checks++; if (bus.req_ready !== (pass != 0) || bus.busy !== (pass == 0)) begin
        errors++; $display("FAIL basewb%0d_state got rdy %b busy %b", pass, bus.req_ready, bus.busy); end
      @(negedge clk);
      if (pass == 0) begin
        checks++; if (bus.rd_we !== 1'b1 || bus.write_rd !== 4'd13 || bus.rd_in !== 32'h1008) begin
          errors++; $display("FAIL basewb_write got %b/%0d/%h exp 1/13/1008", bus.rd_we, bus.write_rd, bus.rd_in); end
      end else begin
        checks++; if (bus.rd_we !== 1'b0) begin errors++; $display("FAIL basewb_skip got %b exp 0", bus.rd_we); end
      end
      checks++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
        errors++; $display("FAIL basewb%0d_end got busy %b rdy %b exp 0 1", pass, bus.busy, bus.req_ready); end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_pc_flags();
    test_burst();
    test_empty_list();
    test_abort();
    test_reset_mid_burst();
`ifdef REGFILE_WB_BASE_WRITEBACK_EN
    test_base_wb();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_writeback_seq.md
Name: regfile_writeback_seq

Overview:
- Writeback sequencer: the initiator that drives the register file's write port (rd_we/rd_in/write_rd, pc_we/pc_in, cpsr_we/cpsr_in).
- Accepts single-result writebacks (ALU, single load) and load-multiple bursts.
- Serializes them to one register write per cycle; routes r15 writes onto the PC port.
- Sits between the execute/memory stages and the register file.

Parameters:
WORD_SIZE, 32, data/PC/CPSR width
NUM_REGS, 16, architectural registers; register-list width
ADDR_WIDTH, 4, register index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
abort  in  1  synchronous cancel of in-flight burst
req_valid  in  1  writeback request valid
req_ready  out  1  request accepted when valid&&ready
req_multi  in  1  0 = single write, 1 = load-multiple
req_rd  in  ADDR_WIDTH  destination (single)
req_data  in  WORD_SIZE  result (single)
req_reglist  in  NUM_REGS  register list (multi)
req_set_flags  in  1  write CPSR (single only)
req_flags  in  WORD_SIZE  new CPSR value
mem_valid  in  1  load-multiple data beat valid
mem_ready  out  1  beat accepted when valid&&ready
mem_data  in  WORD_SIZE  beat data, ascending register order
rd_we  out  1  register write enable
rd_in  out  WORD_SIZE  register write data
write_rd  out  ADDR_WIDTH  register write index
pc_we  out  1  PC write enable
pc_in  out  WORD_SIZE  PC write data
cpsr_we  out  1  CPSR write enable
cpsr_in  out  WORD_SIZE  CPSR write data
busy  out  1  burst in progress (stall upstream)

Behaviour:
- Reset: all outputs 0, state IDLE, pending mask 0; reset mid-burst discards it with no further writes.
- States: IDLE, BURST (plus BASE_WB under option).
- Outputs are registered. A write accepted in cycle N appears for exactly one cycle in N+1; enables are 0 otherwise.
- req_ready = (state==IDLE) && !abort. mem_ready = (state==BURST) && !abort. busy = (state!=IDLE).
- Single accept, rd!=15: rd_we=1, write_rd=rd, rd_in=data.
- Single accept, rd==15: pc_we=1, pc_in=data, rd_we=0, write_rd=0. write_rd never equals 15 while pc_we=1.
- Single accept with req_set_flags=1: additionally cpsr_we=1, cpsr_in=req_flags in the same cycle as the register write.
- Single requests sustain one per cycle; state stays IDLE.
- Multi accept: latch req_reglist into pending mask.
  - Mask 0: no write, stay IDLE.
  - Otherwise: enter BURST. req_set_flags is ignored for multi; no CPSR write.
- BURST beat: each accepted beat writes mem_data to the lowest set pending bit, using the r15 routing above, then clears that bit.
- Last set bit cleared: return to IDLE (or BASE_WB under option). req_ready=1 the following cycle.
- mem_valid=0 in BURST: no write, mask held. mem_valid is ignored in IDLE.
- abort (not under reset): state to IDLE, mask cleared, any beat/request presented that cycle is not accepted and produces no write. Writes already registered from the previous cycle still appear.

Optional Feature:
- Macro: REGFILE_WB_BASE_WRITEBACK_EN.
- When defined:
  - Adds ports req_wb (in, 1), req_rn (in, ADDR_WIDTH) and req_base (in, WORD_SIZE), latched on multi accept.
  - After the last beat's write, state BASE_WB emits one cycle with rd_we=1, write_rd=rn, rd_in=base+4*popcount(reglist), mod 2^WORD_SIZE.
  - The write is skipped (direct return to IDLE) if req_wb=0 or rn is in the reglist. req_ready stays 0 during BASE_WB.
  - abort in BASE_WB cancels the base write.
- When undefined: the ports and BASE_WB state are absent; bursts end at the last beat.

Test Plan:
- Reset, then single rd=3 data=0x12345678 -> next cycle rd_we=1, write_rd=3, rd_in=0x12345678, pc_we=0, cpsr_we=0; all outputs 0 the cycle after.
- Single rd=15 data=0x100 set_flags=1 flags=0x60000000 -> pc_we=1, pc_in=0x100, rd_we=0, write_rd=0, cpsr_we=1, cpsr_in=0x60000000.
- Multi reglist=0x8005, beats 0xA, 0xB, 0xC with a 2-cycle mem_valid gap after the first -> writes r0=0xA, r2=0xB, then pc_we with pc_in=0xC; busy=1 throughout; req_ready=1 the cycle after the last beat.
- Multi reglist=0x0000 -> no writes, req_ready stays 1, busy stays 0.
- Multi reglist=0x000F, abort asserted with the 3rd beat -> only r0, r1 written, busy=0 next cycle; a new single request is accepted the following cycle.
- With REGFILE_WB_BASE_WRITEBACK_EN: reglist=0x0006, rn=13, base=0x1000, wb=1 -> r1, r2 written, then r13=0x1008; repeat with rn=2 -> no base write.
